// File: rtl/pc_fetch_if.sv
// Fetch-side bundle between the pipeline/instruction memory and the PC fetch controller.
// The slave modport is the controller; the master modport is whoever drives it.
interface pc_fetch_if;
    logic        stall;
    logic        branchTaken;
    logic [31:0] PCAddShift;
    logic        imemReady;
    logic [31:0] outPCNext;
    logic [31:0] PCPlus4;
    logic        imemReq;
    logic        misaligned;
    logic [31:0] fetchCount;

    modport master (
        output stall, branchTaken, PCAddShift, imemReady,
        input  outPCNext, PCPlus4, imemReq, misaligned, fetchCount
    );

    modport slave (
        input  stall, branchTaken, PCAddShift, imemReady,
        output outPCNext, PCPlus4, imemReq, misaligned, fetchCount
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request controller with stall handling,
// deferred redirects taken during a stall, and a sticky misaligned-target trap.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic clock,
    input  logic reset,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {BOOT, FETCH, STALL, TRAP} state_t;

    state_t      state_q, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] count_q, count_nxt;
    logic        trap_q, trap_nxt;
    logic        pend_valid_q, pend_valid_nxt;
    logic [31:0] pend_target_q, pend_target_nxt;
    logic        req;
    logic        handshake;
    logic        branch_ok;
    logic        branch_bad;

    assign branch_ok  = bus.branchTaken && (bus.PCAddShift[1:0] == 2'b00);
    assign branch_bad = bus.branchTaken && (bus.PCAddShift[1:0] != 2'b00);
    assign handshake  = req && bus.imemReady;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt       = state_q;
        pc_nxt          = pc_q;
        count_nxt       = count_q;
        trap_nxt        = trap_q;
        pend_valid_nxt  = pend_valid_q;
        pend_target_nxt = pend_target_q;
        req             = 1'b0;

        case (state_q)
            BOOT: state_nxt = FETCH;

            FETCH: begin
                req = !bus.stall;
                if (handshake) count_nxt = count_q + 32'd1;
                if (branch_bad) begin
                    state_nxt = TRAP;
                    trap_nxt  = 1'b1;
                end else if (bus.stall) begin
                    state_nxt = STALL;
                end else if (branch_ok) begin
                    pc_nxt = bus.PCAddShift;
                end else if (handshake) begin
                    pc_nxt = pc_q + 32'd4;
                end
            end

            STALL: begin
                if (branch_bad) begin
                    state_nxt = TRAP;
                    trap_nxt  = 1'b1;
                end else if (!bus.stall) begin
                    // A branch arriving on the release cycle is younger than anything pending.
                    state_nxt      = FETCH;
                    pend_valid_nxt = 1'b0;
                    if (branch_ok)         pc_nxt = bus.PCAddShift;
                    else if (pend_valid_q) pc_nxt = pend_target_q;
                end else if (branch_ok) begin
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = bus.PCAddShift;
                end
            end

            TRAP: ;

            default: state_nxt = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= BOOT;
        else        state_q <= state_nxt;
    end

    // NOTE: the pending target has no functional need for a reset value but is cleared so a reset leaves nothing stale observable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_VECTOR;
            count_q       <= 32'd0;
            trap_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            pc_q          <= pc_nxt;
            count_q       <= count_nxt;
            trap_q        <= trap_nxt;
            pend_valid_q  <= pend_valid_nxt;
            pend_target_q <= pend_target_nxt;
        end
    end

    assign bus.outPCNext  = pc_q;
    assign bus.PCPlus4    = pc_q + 32'd4;
    assign bus.imemReq    = req;
    assign bus.misaligned = trap_q;
    assign bus.fetchCount = count_q;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard stall request from the pipeline.
REQ-005 branchTaken  input  1  redirect request, valid for one cycle.
REQ-006 PCAddShift  input  32  branch target from the PC+immediate adder.
REQ-007 imemReady  input  1  instruction memory accepts the current request.
REQ-008 outPCNext  output  32  current fetch PC; drives instruction memory and the PC+immediate adder.
REQ-009 PCPlus4  output  32  outPCNext+4, combinational, modulo 2^32.
REQ-010 imemReq  output  1  fetch request valid.
REQ-011 misaligned  output  1  sticky trap flag.
REQ-012 fetchCount  output  32  count of completed fetch handshakes.

Function
REQ-013 The FSM SHALL have four states: BOOT, FETCH, STALL and TRAP.
REQ-014 BOOT: imemReq=0; the FSM SHALL go unconditionally to FETCH on the next edge.
REQ-015 FETCH: imemReq SHALL equal !stall (combinational); handshake = imemReq && imemReady.
REQ-016 FETCH, stall=1: PC SHALL be held; next state is STALL; no handshake occurs.
REQ-017 FETCH, branchTaken=1, PCAddShift[1:0]==0: PC SHALL load PCAddShift on the next edge, whether or not a handshake occurs; the outstanding request is abandoned.
REQ-018 FETCH, handshake, no branchTaken: PC SHALL load PCPlus4 on the next edge.
REQ-019 FETCH, no handshake, no branchTaken, no stall: PC SHALL be held and imemReq SHALL stay 1.
REQ-020 Priority in FETCH SHALL be: misaligned branch > stall > aligned branch > sequential advance.
REQ-021 Any branchTaken with PCAddShift[1:0]!=0 (any state except BOOT): the FSM SHALL go to TRAP, set misaligned=1 and hold PC unchanged.
REQ-022 STALL: imemReq=0.
REQ-023 STALL, aligned branchTaken: PCAddShift SHALL be captured into a pending-redirect register and a pending flag set; a later branch overwrites the register (last wins).
REQ-024 STALL exit: when stall=0 the FSM SHALL return to FETCH; PC loads the pending target if the flag is set, otherwise holds; the flag clears.
REQ-025 Branch on the exit cycle: an aligned branchTaken in the same cycle stall falls SHALL take precedence over the pending target.
REQ-026 TRAP: imemReq=0; PC, misaligned and fetchCount SHALL be frozen; only reset exits TRAP.
REQ-027 fetchCount SHALL increment by 1 on each handshake and wrap from 32'hFFFF_FFFF to 0.
REQ-028 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-029 Latency: a handshake or redirect in cycle N SHALL make the new outPCNext visible in cycle N+1.

Reset
REQ-030 While reset=0, asynchronously: state=BOOT, outPCNext=RESET_VECTOR, imemReq=0, misaligned=0, fetchCount=0, pending flag=0, pending target=0.
REQ-031 Reset asserted mid-operation, in any state including TRAP, SHALL abort immediately with no partial update; the first edge after reset release SHALL go to FETCH.

Verification
REQ-032 Boot and sequential fetch: release reset, imemReady=1 constant -> imemReq rises in cycle 2; outPCNext = 0, 4, 8, C on successive cycles; fetchCount=3 after the third handshake.
REQ-033 Backpressure and redirect: PC=0x10, imemReady=0 for 3 cycles -> PC holds 0x10; then branchTaken with PCAddShift=0x100 and no handshake -> PC=0x100 next cycle; fetchCount unchanged.
REQ-034 Stall with pending redirect: PC=0x20, stall=1, branch to 0x200 and then to 0x300 during stall, stall drops -> imemReq=0 during stall; PC=0x300 on the exit edge.
REQ-035 Misaligned trap: branchTaken with PCAddShift=0x102 -> misaligned=1, imemReq=0, PC unchanged; later stimulus is ignored until reset.
REQ-036 Wrap-around: RESET_VECTOR=32'hFFFF_FFF8, imemReady=1 -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Async reset: assert reset between clock edges while in STALL with a pending redirect -> outputs take reset values immediately; the pending redirect is discarded.
